// File: rtl/amba3_apb_sram_slave_pkg.sv
// Shared types and constants for the AMBA 3 APB SRAM slave and its wait-state generator.
//   apb_slv_state_t : slave transfer FSM states
//   apb_wait_mode_t : fixed or pseudo-random wait-state insertion
//   LFSR_TAPS       : feedback taps of the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
//   lfsr_next()     : one right-shift step of that LFSR
package amba3_apb_sram_slave_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } apb_slv_state_t;

    typedef enum logic {
        WaitFixed,
        WaitRandom
    } apb_wait_mode_t;

    // Right-shift form: the taps x^16, x^14, x^13, x^11 land on bits 0, 2, 3, 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned WAIT_CNT_W = 4;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/amba3_apb_wait_gen.sv
// Wait-state generator: a 16-bit LFSR plus a down-counter of remaining wait cycles.
//   pclk     in  clock, rising edge
//   preset_n in  synchronous active-low reset
//   load     in  a new transfer is accepted this cycle; pick N, advance the LFSR once
//   mode     in  fixed (WAIT_STATES) or pseudo-random (LFSR-derived) wait count
//   skip     out the N selected for a load this cycle is zero
//   zero     out no wait cycles remain for the transfer in progress
module amba3_apb_wait_gen
    import amba3_apb_sram_slave_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned WAIT_MAX    = 10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic           pclk,
    input  logic           preset_n,
    input  logic           load,
    input  apb_wait_mode_t mode,
    output logic           skip,
    output logic           zero
);

    logic [15:0]           lfsr_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] n;

    always_comb begin
        n = WAIT_CNT_W'(WAIT_STATES);
        if (mode == WaitRandom) begin
            n = '0;
            if (lfsr_q[0]) begin
                n = WAIT_CNT_W'((32'(lfsr_q[7:4]) % WAIT_MAX) + 32'd1);
            end
        end
        skip = (n == '0);
        zero = (cnt_q == '0);
    end

    // The counter holds N-1 after a load, so the owner leaves its wait state on the
    // edge where zero is seen and the data phase lands exactly N cycles after setup.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= '0;
        end else if (load) begin
            lfsr_q <= lfsr_next(lfsr_q);
            cnt_q  <= skip ? '0 : n - WAIT_CNT_W'(1);
        end else if (!zero) begin
            cnt_q <= cnt_q - WAIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/amba3_apb_sram_slave.sv
// AMBA 3 APB slave backed by a word-addressed SRAM array, with PREADY wait-state insertion
// (fixed or LFSR-driven) and PSLVERR on out-of-range or misaligned accesses.
//   pclk     in  APB clock
//   preset_n in  synchronous active-low reset
//   psel     in  slave select
//   penable  in  access phase
//   pwrite   in  1 = write, 0 = read
//   paddr    in  byte address
//   pwdata   in  write data, sampled in the completing cycle
//   prdata   out read data, registered; zero except in the completing cycle of a good read
//   pready   out transfer complete, one cycle per transfer
//   pslverr  out error response, only alongside pready
module amba3_apb_sram_slave
    import amba3_apb_sram_slave_pkg::*;
#(
    parameter int unsigned           ADDR_SIZE   = 32,
    parameter int unsigned           DATA_SIZE   = 32,
    parameter int unsigned           DEPTH       = 1024,
    parameter logic [ADDR_SIZE-1:0]  BASE_ADDR   = '0,
    parameter int unsigned           WAIT_MODE   = 0,
    parameter int unsigned           WAIT_STATES = 0,
    parameter int unsigned           WAIT_MAX    = 10,
    parameter logic [15:0]           LFSR_SEED   = 16'hACE1
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int unsigned BYTES     = DATA_SIZE / 8;
    localparam int unsigned DATA_BASE = $clog2(BYTES);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1       = ADDR_SIZE + 1;

    // One extra bit so a window ending at the top of the address space does not wrap.
    localparam logic [ADDR_SIZE:0]   END_ADDR  = {1'b0, BASE_ADDR} + AW1'(DEPTH * BYTES);
    localparam logic [ADDR_SIZE-1:0] ADDR_MASK = ADDR_SIZE'(BYTES - 1);

    localparam apb_wait_mode_t MODE = (WAIT_MODE != 0) ? WaitRandom : WaitFixed;

    apb_slv_state_t       state_q;
    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [IDX_W-1:0]     idx_q;
    logic                 err_q;
    logic                 write_q;
    logic [DATA_SIZE-1:0] prdata_q;
    logic                 pready_q;
    logic                 pslverr_q;

    logic                 load;
    logic                 skip;
    logic                 zero;
    logic                 err;
    logic [ADDR_SIZE-1:0] offset;
    logic [IDX_W-1:0]     idx;
    logic                 fin_go;
    logic                 fin_err;
    logic                 fin_write;
    logic [IDX_W-1:0]     fin_idx;

    amba3_apb_wait_gen #(
        .WAIT_STATES (WAIT_STATES),
        .WAIT_MAX    (WAIT_MAX),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait_gen (
        .pclk     (pclk),
        .preset_n (preset_n),
        .load     (load),
        .mode     (MODE),
        .skip     (skip),
        .zero     (zero)
    );

    always_comb begin
        // A setup phase is accepted from IDLE or straight out of DONE.
        load   = psel & ~penable & (state_q != StWait);
        offset = paddr - BASE_ADDR;
        idx    = IDX_W'(offset >> DATA_BASE);
        err    = (paddr < BASE_ADDR) | ({1'b0, paddr} >= END_ADDR) |
                 ((paddr & ADDR_MASK) != '0);

        // A zero-wait transfer completes straight from setup, so use the live decode.
        fin_go    = (load & skip) | ((state_q == StWait) & psel & penable & zero);
        fin_err   = load ? err    : err_q;
        fin_write = load ? pwrite : write_q;
        fin_idx   = load ? idx    : idx_q;
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= fin_go;
            pslverr_q <= fin_go & fin_err;
            prdata_q  <= (fin_go & ~fin_write & ~fin_err) ? mem[fin_idx] : '0;

            if (load) begin
                idx_q   <= idx;
                err_q   <= err;
                write_q <= pwrite;
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (load) begin
                        state_q <= skip ? StDone : StWait;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (!psel) begin
                        state_q <= StIdle;
                    end else if (penable && zero) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Contents survive reset; a reset during DONE drops the pending write.
    always_ff @(posedge pclk) begin
        if (preset_n && (state_q == StDone) && write_q && !err_q) begin
            mem[idx_q] <= pwdata;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_amba3_apb_sram_slave.sv
module tb_amba3_apb_sram_slave;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        preset_n;
    logic [NI-1:0] psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    wire  [31:0] prdata [NI];
    wire  [NI-1:0] pready;
    wire  [NI-1:0] pslverr;

    // Per-instance configuration as seen by the reference model.
    int unsigned base_of [NI] = '{32'h0, 32'h0, 32'h1000, 32'h0, 32'h0};
    int          fixed_n [NI] = '{0, 3, 2, -1, 4};

    logic [31:0] ref_mem [NI][1024];
    logic [15:0] m_lfsr;
    int          checks = 0;
    int          failures = 0;
    int          zero_cnt = 0;
    int          rnd_cnt = 0;
    int          max_k = 0;

    always #5 clk = ~clk;

    amba3_apb_sram_slave #(.WAIT_MODE(0), .WAIT_STATES(0)) u_a (
        .pclk(clk), .preset_n(preset_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]));
    amba3_apb_sram_slave #(.WAIT_MODE(0), .WAIT_STATES(3)) u_b (
        .pclk(clk), .preset_n(preset_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]));
    amba3_apb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h1000), .WAIT_MODE(0),
                           .WAIT_STATES(2)) u_c (
        .pclk(clk), .preset_n(preset_n), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]));
    amba3_apb_sram_slave #(.WAIT_MODE(1), .WAIT_MAX(10), .LFSR_SEED(16'hACE1)) u_d (
        .pclk(clk), .preset_n(preset_n), .psel(psel[3]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[3]), .pready(pready[3]),
        .pslverr(pslverr[3]));
    amba3_apb_sram_slave #(.WAIT_MODE(0), .WAIT_STATES(4)) u_e (
        .pclk(clk), .preset_n(preset_n), .psel(psel[4]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[4]), .pready(pready[4]),
        .pslverr(pslverr[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait count the random instance will pick for its next accepted setup.
    function automatic int peek_n();
        int l;
        l = int'(m_lfsr);
        if (l % 2 == 0) return 0;
        return ((l / 16) % 16) % 10 + 1;
    endfunction

    function automatic void step_lfsr();
        int l;
        int b;
        l = int'(m_lfsr);
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        m_lfsr = 16'((l >> 1) | (b << 15));
    endfunction

    function automatic int exp_wait(input int i);
        int n;
        if (fixed_n[i] >= 0) return fixed_n[i];
        n = peek_n();
        step_lfsr();
        return n;
    endfunction

    // One full APB transfer on instance i, checked against the model.
    task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
        int          n;
        int          k;
        bit          e;
        int unsigned idx;
        e   = (a < base_of[i]) || (a >= base_of[i] + 4096) || (a % 4 != 0);
        idx = (a - base_of[i]) / 4;
        n   = exp_wait(i);
        @(negedge clk);
        psel = '0;
        psel[i] = 1'b1;
        penable = 1'b0;
        pwrite = w;
        paddr = a;
        pwdata = ~d;
        @(negedge clk);
        penable = 1'b1;
        pwdata = d;
        k = 0;
        while (!pready[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".wait"}, k, n);
        check({tag, ".err"}, pslverr[i], e);
        if (!w) check({tag, ".rdata"}, prdata[i], e ? 32'h0 : ref_mem[i][idx]);
        if (w && !e) ref_mem[i][idx] = d;
        if (i == 3) begin
            rnd_cnt++;
            if (k == 0) zero_cnt++;
            if (k > max_k) max_k = k;
        end
        @(negedge clk);
        psel = '0;
        penable = 1'b0;
        check({tag, ".one_cycle"}, {30'd0, pready[i], pslverr[i]}, 32'h0);
        check({tag, ".rdata_idle"}, prdata[i], 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          guard;
        logic [31:0] a;
        preset_n = 1'b0;
        psel = '0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        m_lfsr = 16'hACE1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset.pready%0d", i), {31'd0, pready[i]}, 32'h0);
            check($sformatf("reset.pslverr%0d", i), {31'd0, pslverr[i]}, 32'h0);
            check($sformatf("reset.prdata%0d", i), prdata[i], 32'h0);
        end
        preset_n = 1'b1;

        // Zero-wait write then read.
        xfer(0, 1'b1, 32'h40, 32'h80003333, "a_wr");
        xfer(0, 1'b0, 32'h40, 32'h0, "a_rd");

        // Three fixed wait states.
        xfer(1, 1'b1, 32'h800, 32'h00040000, "b_wr");
        xfer(1, 1'b0, 32'h800, 32'h0, "b_rd");

        // Window at 0x1000..0x1FFF: last word, below-range write, above-range and misaligned reads.
        xfer(2, 1'b1, 32'h1FFC, 32'hA5A5F00D, "c_wr_last");
        xfer(2, 1'b1, 32'h0FFC, 32'hDEADBEEF, "c_wr_low");
        xfer(2, 1'b0, 32'h1FFC, 32'h0, "c_rd_last");
        xfer(2, 1'b0, 32'h2000, 32'h0, "c_rd_high");
        xfer(2, 1'b1, 32'h1000, 32'h13572468, "c_wr_first");
        xfer(2, 1'b0, 32'h1002, 32'h0, "c_rd_mis");
        xfer(2, 1'b0, 32'h1000, 32'h0, "c_rd_first");

        // Pseudo-random waits: fill 16 words, then random traffic with some bad addresses.
        for (int j = 0; j < 16; j++) xfer(3, 1'b1, 32'(j * 4), $urandom, "d_fill");
        for (int j = 0; j < 184; j++) begin
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 15) == 0) a = a | 32'h1;
            else if ($urandom_range(0, 15) == 0) a = a | 32'h4000;
            xfer(3, 1'($urandom_range(0, 1)), a, $urandom, "d_rand");
        end
        check("d_rand.max_wait_le10", {31'd0, max_k <= 10}, 32'h1);
        check("d_rand.half_zero", {31'd0, (zero_cnt * 10 >= rnd_cnt * 3) &&
                                          (zero_cnt * 10 <= rnd_cnt * 7)}, 32'h1);

        // Aborted write: psel dropped one cycle into the access phase.
        xfer(4, 1'b1, 32'h84, 32'h11112222, "e_wr");
        @(negedge clk);
        psel = 5'b10000;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h84;
        pwdata = 32'h04400011;
        @(negedge clk);
        penable = 1'b1;
        check("e_abort.t1", {31'd0, pready[4]}, 32'h0);
        @(negedge clk);
        psel = '0;
        penable = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check("e_abort.no_ready", {31'd0, pready[4]}, 32'h0);
            @(negedge clk);
        end
        xfer(4, 1'b0, 32'h84, 32'h0, "e_rd");

        // Reset during a wait state of the random instance.
        guard = 0;
        while (peek_n() == 0 && guard < 30) begin
            xfer(3, 1'b0, 32'h0, 32'h0, "r_pre");
            guard++;
        end
        n = exp_wait(3);
        @(negedge clk);
        psel = 5'b01000;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h8;
        pwdata = 32'h5A5A0000;
        @(negedge clk);
        penable = 1'b1;
        check("rst.in_wait", {31'd0, pready[3]}, 32'h0);
        preset_n = 1'b0;
        @(negedge clk);
        check("rst.pready", {31'd0, pready[3]}, 32'h0);
        check("rst.pslverr", {31'd0, pslverr[3]}, 32'h0);
        check("rst.prdata", prdata[3], 32'h0);
        preset_n = 1'b1;
        psel = '0;
        penable = 1'b0;
        m_lfsr = 16'hACE1;
        xfer(3, 1'b0, 32'h8, 32'h0, "rst_rd");
        xfer(3, 1'b1, 32'h8, 32'h0BADCAFE, "rst_wr");
        xfer(3, 1'b0, 32'h8, 32'h0, "rst_rd2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
